// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared constants, FSM states and slot clamp for systolic_feeder
// Purpose: frame geometry, minimum PE slot count, issue FSM encoding and the
//          slot_len clamp used when a frame is loaded.
// Ports:   none (package).
package systolic_feeder_pkg;

  localparam int FRAME_LEN = 8;
  localparam int MIN_SLOT  = 17;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } feeder_state_t;

  function automatic logic [31:0] clamp_slot(input logic [31:0] t);
    return (t < 32'(MIN_SLOT)) ? 32'(MIN_SLOT) : t;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - sample stream and PE-side bundle for systolic_feeder
// Purpose: groups the sample handshake, slot request and PE drive signals.
// Ports:   in_word/in_valid/in_ready  sample handshake into the feeder
//          slot_len                   requested PE slot count
//          inputword/timing/pe_reset  PE drive
//          word_index/word_strobe/frame_done  slot progress flags
interface systolic_feeder_if #(parameter int WORDLENGTH = 16);

  logic [WORDLENGTH-1:0] in_word;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           slot_len;
  logic [WORDLENGTH-1:0] inputword;
  logic [31:0]           timing;
  logic                  pe_reset;
  logic [2:0]            word_index;
  logic                  word_strobe;
  logic                  frame_done;

  modport master (
    output in_word, in_valid, slot_len,
    input  in_ready, inputword, timing, pe_reset, word_index, word_strobe, frame_done
  );

  modport slave (
    input  in_word, in_valid, slot_len,
    output in_ready, inputword, timing, pe_reset, word_index, word_strobe, frame_done
  );

endinterface

// File: rtl/systolic_feeder_bank.sv
// rtl/systolic_feeder_bank.sv - one FRAME_LEN x WORDLENGTH frame bank with full flag
// Purpose: write port, asynchronous read port, full flag set on fill wrap and
//          cleared when the frame has been issued.
// Ports:   clk30x, reset (sync active-low), wr_en/wr_addr/wr_data,
//          rd_addr/rd_data, set_full, clr_full, full
module systolic_feeder_bank
  import systolic_feeder_pkg::*;
#(
  parameter int WORDLENGTH = 16
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [WORDLENGTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [WORDLENGTH-1:0] rd_data,
  input  logic                  set_full,
  input  logic                  clr_full,
  output logic                  full
);

  logic [WORDLENGTH-1:0] mem [FRAME_LEN];

  // Data needs no reset: the full flag and write pointer decide what is valid.
  always_ff @(posedge clk30x) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk30x) begin
    if (!reset)        full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - ping-pong frame collector and slot sequencer for the PE
// Purpose: fills two frame banks from the sample stream and issues each frame
//          to the PE one word per slot after a one-cycle pe_reset.
// Ports:   clk30x  sole clock
//          reset   synchronous, active-low
//          bus     systolic_feeder_if slave (stream in, PE drive out)
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int WORDLENGTH = 16
) (
  input  logic                 clk30x,
  input  logic                 reset,
  systolic_feeder_if.slave     bus
);

  feeder_state_t         state, state_nx;
  logic                  fill_sel, issue_sel;
  logic [IDX_W-1:0]      wr_ptr, word_index;
  logic [31:0]           slot_cnt, timing;
  logic [1:0]            full, set_full, clr_full, full_nx;
  logic [WORDLENGTH-1:0] rd_data [2];
  logic                  accept, wrap, slot_end, pe_reset, word_strobe, frame_done;

  // The fill bank is only full when both banks are, so this is the only stall.
  assign bus.in_ready = ~full[fill_sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign wrap         = accept & (wr_ptr == IDX_W'(FRAME_LEN - 1));

  always_comb begin
    set_full           = '0;
    set_full[fill_sel] = wrap;
  end

  // Look ahead at the flag being set this edge so LOAD follows the 8th accept directly.
  assign full_nx = full | set_full;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    systolic_feeder_bank #(.WORDLENGTH(WORDLENGTH)) u_bank (
      .clk30x   (clk30x),
      .reset    (reset),
      .wr_en    (accept && (fill_sel == 1'(b))),
      .wr_addr  (wr_ptr),
      .wr_data  (bus.in_word),
      .rd_addr  (word_index),
      .rd_data  (rd_data[b]),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .full     (full[b])
    );
  end

  always_ff @(posedge clk30x) begin
    if (!reset) begin
      wr_ptr   <= '0;
      fill_sel <= 1'b0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 3'd1;
      if (wrap) fill_sel <= ~fill_sel;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_full    = '0;
    pe_reset    = 1'b0;
    word_strobe = 1'b0;
    frame_done  = 1'b0;
    // Slot 0 is one cycle longer: the PE spends its first post-reset cycle at count -1.
    slot_end    = (slot_cnt == ((word_index == '0) ? timing + 32'd1 : timing));
    case (state)
      IDLE: begin
        if (full_nx[issue_sel]) state_nx = LOAD;
      end
      LOAD: begin
        pe_reset = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        word_strobe = (slot_cnt == '0);
        if (slot_end && (word_index == IDX_W'(FRAME_LEN - 1))) begin
          frame_done          = 1'b1;
          clr_full[issue_sel] = 1'b1;
          state_nx            = full_nx[~issue_sel] ? LOAD : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk30x) begin
    if (!reset) begin
      state      <= IDLE;
      issue_sel  <= 1'b0;
      word_index <= '0;
      slot_cnt   <= '0;
      timing     <= 32'(MIN_SLOT);
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          timing     <= clamp_slot(bus.slot_len);
          word_index <= '0;
          slot_cnt   <= '0;
        end
        ISSUE: begin
          if (slot_end) begin
            slot_cnt   <= '0;
            word_index <= word_index + 3'd1;
            if (word_index == IDX_W'(FRAME_LEN - 1)) issue_sel <= ~issue_sel;
          end else begin
            slot_cnt <= slot_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inputword   = (state == ISSUE) ? rd_data[issue_sel] : '0;
  assign bus.timing      = timing;
  assign bus.pe_reset    = pe_reset;
  assign bus.word_index  = word_index;
  assign bus.word_strobe = word_strobe;
  assign bus.frame_done  = frame_done;

endmodule
